// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and aluControl.
// Holds the R-type opcode/function codes that route an instruction to the
// mul/div sequencer and the 2-bit state encoding of the sequencer FSM.
package muldiv_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] FUN_MUL  = 4'd4;
  localparam logic [3:0] FUN_DIV  = 4'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_DIV  = ST_DIV,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath, one bit per stepMul/stepDiv.
// Ports: load latches operands (divSel picks the divide arrangement);
// hi/lo are the post-step values, i.e. what the registers hold after this step.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             divSel,
  input  logic             stepMul,
  input  logic             stepDiv,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // acc: product high half / partial remainder.
  // shf: multiplier shifting out LSB-first / dividend shifting out MSB-first
  //      while quotient bits shift in at the bottom.
  // opd: multiplicand (MUL) or divisor (DIV).
  logic [WIDTH-1:0] acc_q, shf_q, opd_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_hi, div_lo;

  always_comb begin
    // Conditional add, then shift the whole {carry,acc,shf} right by one.
    mul_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opd_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], shf_q[WIDTH-1:1]};

    // Bring the next dividend bit into the remainder and trial-subtract.
    // When the subtraction succeeds the true difference is below the
    // divisor, so the W-bit modular result is exact.
    div_shift = {acc_q, shf_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opd_q};
    div_diff  = div_shift[WIDTH-1:0] - opd_q;
    div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_lo    = {shf_q[WIDTH-2:0], div_ge};

    hi = stepDiv ? div_hi : mul_hi;
    lo = stepDiv ? div_lo : mul_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      shf_q <= '0;
      opd_q <= '0;
    end else if (load) begin
      acc_q <= '0;
      shf_q <= divSel ? operandA : operandB;
      opd_q <= divSel ? operandB : operandA;
    end else if (stepMul) begin
      acc_q <= mul_hi;
      shf_q <= mul_lo;
    end else if (stepDiv) begin
      acc_q <= div_hi;
      shf_q <= div_lo;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for the shared iterative 16-bit unsigned MUL/DIV unit.
// Ports: start/opCode/funCode/operands/flush in; stall, busy, one-cycle done,
// {resultHi,resultLo} and divByZero out. Latency WIDTH+1 cycles (1 for DIV by 0).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opCode,
  input  logic [3:0]       funCode,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultLo,
  output logic [WIDTH-1:0] resultHi,
  output logic             divByZero
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             dbz_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;

  logic             is_muldiv, accept, div_zero, last_step, iterating;
  logic             step_mul, step_div;
  logic [WIDTH-1:0] dp_hi, dp_lo;

  always_comb begin
    is_muldiv = start && (opCode == OP_RTYPE) &&
                ((funCode == FUN_MUL) || (funCode == FUN_DIV));
    // A flushed instruction is never accepted, so it never stalls the pipe.
    accept    = is_muldiv && (state_q == S_IDLE) && !flush;
    div_zero  = (funCode == FUN_DIV) && (operandB == '0);
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    iterating = (state_q == S_MUL) || (state_q == S_DIV);
    step_mul  = (state_q == S_MUL) && !flush;
    step_div  = (state_q == S_DIV) && !flush;

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (funCode == FUN_MUL)  state_d = S_MUL;
          else if (div_zero)       state_d = S_DONE;
          else                     state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)          state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Low in DONE so the EX instruction advances together with its result.
    stall     = accept || iterating;
    done      = (state_q == S_DONE);
    busy      = busy_q;
    resultLo  = res_lo_q;
    resultHi  = res_hi_q;
    divByZero = dbz_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      dbz_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_MUL) || (state_d == S_DIV);

      if (accept)
        cnt_q <= '0;
      else if (iterating && !last_step)
        cnt_q <= cnt_q + 1'b1;

      // Results only change on entry to DONE, so a flushed op leaves the
      // previous result visible.
      if (accept && (funCode == FUN_DIV) && div_zero) begin
        res_lo_q <= '1;
        res_hi_q <= operandA;
        dbz_q    <= 1'b1;
      end else if (accept) begin
        dbz_q    <= 1'b0;
      end else if ((step_mul || step_div) && last_step) begin
        res_lo_q <= dp_lo;
        res_hi_q <= dp_hi;
      end
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .divSel   (funCode == FUN_DIV),
    .stepMul  (step_mul),
    .stepDiv  (step_div),
    .operandA (operandA),
    .operandB (operandB),
    .hi       (dp_hi),
    .lo       (dp_lo)
  );

endmodule
